// File: rtl/car_dispatch_pkg.sv
// car_dispatch_pkg: shared FSM states, floor count, default tick period and the state-code helper
package car_dispatch_pkg;
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} fsm_t;
  localparam int NUM_FLOORS = 4;
  localparam int TICK_MAX_DEF = 100_000_000;
  function automatic logic [4:0] code(input logic [1:0] target, input logic [1:0] cur);
    return {1'b0, target, 2'b00} + {3'b000, cur} + 5'd1;
  endfunction
endpackage

// File: rtl/car_dispatch_floor_tick.sv
// floor_tick: prescaler; clk, rst (async high), en counts, clr zeroes, tick pulses on count TICK_MAX-1
module floor_tick
  import car_dispatch_pkg::*;
#(
  parameter int TICK_MAX = TICK_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = TICK_MAX > 1 ? $clog2(TICK_MAX) : 1;
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(TICK_MAX - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/car_dispatch.sv
// car_dispatch: elevator scheduler; req in, state code / cur_floor / dir_up / moving / door_open / served out
module car_dispatch
  import car_dispatch_pkg::*;
#(
  parameter int TICK_MAX   = TICK_MAX_DEF,
  parameter int DOOR_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [4:0] state,
  output logic [1:0] cur_floor,
  output logic       dir_up,
  output logic       moving,
  output logic       door_open,
  output logic [3:0] served
);
  localparam int DW = $clog2(DOOR_TICKS);
  fsm_t fsm;
  logic [1:0] target, nxt;
  logic [DW-1:0] dcnt;
  logic tick;
  logic [3:0] sel_cur, sel_nxt;
  // returns {found, dir_up, target}; the nearest request in the travel direction wins, else nearest behind
  function automatic logic [3:0] pick(input logic [3:0] r, input logic [1:0] f, input logic up);
    logic [2:0] hi, lo;
    logic [3:0] a, b;
    a = '0;
    b = '0;
    for (int d = 3; d >= 1; d--) begin
      hi = {1'b0, f} + 3'(d);
      lo = {1'b0, f} - 3'(d);
      if (!hi[2] && r[hi[1:0]]) begin
        if (up) a = {2'b11, hi[1:0]};
        else b = {2'b11, hi[1:0]};
      end
      if (!lo[2] && r[lo[1:0]]) begin
        if (up) b = {2'b10, lo[1:0]};
        else a = {2'b10, lo[1:0]};
      end
    end
    return a[3] ? a : b;
  endfunction
  floor_tick #(.TICK_MAX(TICK_MAX)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (fsm != IDLE),
    .clr (fsm == IDLE),
    .tick(tick)
  );
  // the floor reached by the step in progress; saturates so no step leaves the shaft
  assign nxt = dir_up ? (cur_floor == 2'd3 ? 2'd3 : cur_floor + 2'd1)
                      : (cur_floor == 2'd0 ? 2'd0 : cur_floor - 2'd1);
  assign sel_cur = pick(req, cur_floor, dir_up);
  assign sel_nxt = pick(req, nxt, dir_up);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      cur_floor <= '0;
      target    <= '0;
      dir_up    <= 1'b1;
      moving    <= 1'b0;
      door_open <= 1'b0;
      served    <= '0;
      dcnt      <= '0;
      state     <= '0;
    end else begin
      served <= '0;
      case (fsm)
        IDLE:
          if (req[cur_floor]) begin
            fsm       <= DOOR;
            door_open <= 1'b1;
            served    <= 4'b1 << cur_floor;
            target    <= cur_floor;
            state     <= code(cur_floor, cur_floor);
          end else if (sel_cur[3]) begin
            fsm    <= MOVE;
            moving <= 1'b1;
            dir_up <= sel_cur[2];
            target <= sel_cur[1:0];
            state  <= code(sel_cur[1:0], cur_floor);
          end
        MOVE:
          if (tick) begin
            cur_floor <= nxt;
            if (req[nxt]) begin
              fsm       <= DOOR;
              moving    <= 1'b0;
              door_open <= 1'b1;
              served    <= 4'b1 << nxt;
              target    <= nxt;
              state     <= code(nxt, nxt);
            end else if (sel_nxt[3]) begin
              dir_up <= sel_nxt[2];
              target <= sel_nxt[1:0];
              state  <= code(sel_nxt[1:0], nxt);
            end else begin
              fsm    <= IDLE;
              moving <= 1'b0;
              state  <= '0;
            end
          end
        DOOR:
          if (tick) begin
            dcnt <= dcnt + 1'b1;
            if (dcnt == DW'(DOOR_TICKS - 1)) begin
              fsm       <= IDLE;
              door_open <= 1'b0;
              state     <= '0;
              dcnt      <= '0;
            end
          end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_car_dispatch.sv
// tb_car_dispatch: directed and randomized trips checked against a trip-level reference model
module tb_car_dispatch;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic [4:0] state;
  logic [1:0] cur_floor;
  logic dir_up, moving, door_open;
  logic [3:0] served;
  int compared = 0;
  int mismatched = 0;
  int m_cur;
  bit m_dir;
  car_dispatch #(.TICK_MAX(4), .DOOR_TICKS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .state    (state),
    .cur_floor(cur_floor),
    .dir_up   (dir_up),
    .moving   (moving),
    .door_open(door_open),
    .served   (served)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // wait for the car to serve floor f, checking travel, arrival time and the full door cycle
  task automatic serve(input int f, input int t0, input int exp_t, input bit mv_chk, input bit rnd);
    int t, sgn, pos;
    logic [3:0] add;
    t = t0;
    sgn = f > m_cur ? 1 : -1;
    while (served === 4'b0 && t < t0 + 80) begin
      step();
      t++;
      if (served === 4'b0 && mv_chk) begin
        pos = m_cur + sgn * ((t - 1) / 4);
        chk("move_floor", cur_floor, pos);
        chk("move_state", state, 4 * f + pos + 1);
        chk("move_flag", moving, 1);
      end
    end
    if (f != m_cur) m_dir = f > m_cur;
    m_cur = f;
    chk("arrive_time", t, exp_t);
    chk("served", served, 32'(1) << f);
    chk("arrive_floor", cur_floor, f);
    chk("door_state", state, 5 * f + 1);
    chk("door_open", door_open, 1);
    chk("dir_up", dir_up, m_dir);
    req[f] = 1'b0;
    if (rnd) begin
      add = 4'($urandom) & ~(4'b1 << f);
      req = req | add;
    end
    step();
    chk("served_pulse", served, 0);
    chk("door_hold", door_open, 1);
    repeat (6) step();
    chk("door_last", door_open, 1);
    chk("door_last_state", state, 5 * f + 1);
    step();
    chk("door_closed", door_open, 0);
    chk("idle_state", state, 0);
    chk("idle_moving", moving, 0);
  endtask
  task automatic do_trip(input bit rnd);
    int f, g, k;
    f = -1;
    if (req[m_cur]) f = m_cur;
    for (int pass = 0; pass < 2; pass++)
      for (int d = 1; d <= 3; d++) begin
        g = ((pass == 0) == m_dir) ? m_cur + d : m_cur - d;
        if (f < 0 && g >= 0 && g <= 3 && req[g]) f = g;
      end
    k = f > m_cur ? f - m_cur : m_cur - f;
    serve(f, 0, 1 + 4 * k, 1'b1, rnd);
  endtask
  initial begin
    rst = 1'b1;
    req = 4'b0;
    m_cur = 0;
    m_dir = 1'b1;
    repeat (2) step();
    chk("rst_state", state, 0);
    chk("rst_dir", dir_up, 1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("idle_hold_state", state, 0);
      chk("idle_hold_floor", cur_floor, 0);
      chk("idle_hold_door", door_open, 0);
    end
    req = 4'b0001;
    do_trip(1'b0);
    req = 4'b1000;
    do_trip(1'b0);
    req = 4'b0001;
    do_trip(1'b0);
    req = 4'b1000;
    repeat (6) step();
    chk("mid_floor", cur_floor, 1);
    chk("mid_moving", moving, 1);
    req[2] = 1'b1;
    serve(2, 6, 9, 1'b0, 1'b0);
    do_trip(1'b0);
    req = 4'b0001;
    do_trip(1'b0);
    req = 4'b0100;
    do_trip(1'b0);
    req = 4'b0011;
    do_trip(1'b0);
    do_trip(1'b0);
    req = 4'b0100;
    repeat (6) step();
    chk("pre_rst_floor", cur_floor, 1);
    rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_floor", cur_floor, 0);
    chk("arst_dir", dir_up, 1);
    chk("arst_moving", moving, 0);
    chk("arst_door", door_open, 0);
    chk("arst_served", served, 0);
    step();
    rst = 1'b0;
    m_cur = 0;
    m_dir = 1'b1;
    do_trip(1'b0);
    repeat (40) begin
      if (req == 4'b0) req = 4'($urandom_range(1, 15));
      do_trip(1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
